// File: rtl/pyrm_mem_pkg.sv
// Shared types for the memory arbiter: FSM state, requester ID and its encodings.
// Optional round-robin arbitration is selected by defining PYRM_ARB_ROUND_ROBIN_EN.
package pyrm_mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_FETCH = 1'b0;
  localparam req_id_t REQ_DATA  = 1'b1;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/pyrm_id_fifo.sv
// Outstanding-request ID tracker: a small FIFO whose head names the requester
// owning the next in-order memory response.
module pyrm_id_fifo
  import pyrm_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  req_id_t i_push_id,
  input  logic    i_pop,
  output logic    o_full,
  output logic    o_empty,
  output req_id_t o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  req_id_t       r_mem [DEPTH];

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pyrm_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port with in-order response
// routing. Define PYRM_ARB_ROUND_ROBIN_EN for round-robin; default is data-first priority.
module pyrm_mem_arbiter
  import pyrm_mem_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset_pyri,
  input  logic        if_req_valid_pyri,
  input  logic [63:0] if_req_addr_pyri,
  output logic        if_req_retry_pyro,
  input  logic        dc_req_valid_pyri,
  input  logic [63:0] dc_req_addr_pyri,
  input  logic        dc_req_we_pyri,
  input  logic [63:0] dc_req_wdata_pyri,
  output logic        dc_req_retry_pyro,
  output logic        mem_req_valid_pyro,
  output logic [63:0] mem_req_addr_pyro,
  output logic        mem_req_we_pyro,
  output logic [63:0] mem_req_wdata_pyro,
  input  logic        mem_req_retry_pyri,
  input  logic        mem_resp_valid_pyri,
  input  logic [63:0] mem_resp_data_pyri,
  output logic        mem_resp_retry_pyro,
  output logic        if_resp_valid_pyro,
  output logic [63:0] if_resp_data_pyro,
  input  logic        if_resp_retry_pyri,
  output logic        dc_resp_valid_pyro,
  output logic [63:0] dc_resp_data_pyro,
  input  logic        dc_resp_retry_pyri
);

  arb_state_t  r_state;
  req_id_t     r_hold_id;
  logic [63:0] r_hold_addr;
  logic        r_hold_we;
  logic [63:0] r_hold_wdata;
`ifdef PYRM_ARB_ROUND_ROBIN_EN
  req_id_t     r_rr_ptr;
`endif

  req_id_t     w_idle_sel;
  req_id_t     w_sel;
  req_id_t     w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_cand;
  logic        w_head_retry;
  logic        w_pop;
  logic        w_xfer;

  always_comb begin
    w_idle_sel = REQ_FETCH;
    if (dc_req_valid_pyri && !if_req_valid_pyri) begin
      w_idle_sel = REQ_DATA;
    end else if (dc_req_valid_pyri && if_req_valid_pyri) begin
`ifdef PYRM_ARB_ROUND_ROBIN_EN
      w_idle_sel = r_rr_ptr;
`else
      w_idle_sel = REQ_DATA;
`endif
    end
  end

  assign w_sel  = (r_state == HOLD) ? r_hold_id : w_idle_sel;
  assign w_cand = (r_state == HOLD) | if_req_valid_pyri | dc_req_valid_pyri;

  // Response side only depends on inputs, so a full tracker can admit a
  // request in the very cycle a response drains it.
  assign w_head_retry = (w_head == REQ_FETCH) ? if_resp_retry_pyri : dc_resp_retry_pyri;
  assign w_pop        = ~reset_pyri & mem_resp_valid_pyri & ~w_empty & ~w_head_retry;

  assign mem_req_valid_pyro = ~reset_pyri & w_cand & (~w_full | w_pop);
  assign w_xfer             = mem_req_valid_pyro & ~mem_req_retry_pyri;

  always_comb begin
    mem_req_addr_pyro  = if_req_addr_pyri;
    mem_req_we_pyro    = 1'b0;
    mem_req_wdata_pyro = '0;
    if (r_state == HOLD) begin
      mem_req_addr_pyro  = r_hold_addr;
      mem_req_we_pyro    = r_hold_we;
      mem_req_wdata_pyro = r_hold_wdata;
    end else if (w_sel == REQ_DATA) begin
      mem_req_addr_pyro  = dc_req_addr_pyri;
      mem_req_we_pyro    = dc_req_we_pyri;
      mem_req_wdata_pyro = dc_req_wdata_pyri;
    end
  end

  assign if_req_retry_pyro = ~(mem_req_valid_pyro & (w_sel == REQ_FETCH)) | mem_req_retry_pyri;
  assign dc_req_retry_pyro = ~(mem_req_valid_pyro & (w_sel == REQ_DATA))  | mem_req_retry_pyri;

  assign mem_resp_retry_pyro = ~w_empty & w_head_retry;
  assign if_resp_valid_pyro  = mem_resp_valid_pyri & ~w_empty & (w_head == REQ_FETCH);
  assign dc_resp_valid_pyro  = mem_resp_valid_pyri & ~w_empty & (w_head == REQ_DATA);
  assign if_resp_data_pyro   = mem_resp_data_pyri;
  assign dc_resp_data_pyro   = mem_resp_data_pyri;

  always_ff @(posedge clk or posedge reset_pyri) begin
    if (reset_pyri) begin
      r_state      <= IDLE;
      r_hold_id    <= REQ_FETCH;
      r_hold_addr  <= '0;
      r_hold_we    <= 1'b0;
      r_hold_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req_valid_pyro && mem_req_retry_pyri) begin
            r_state      <= HOLD;
            r_hold_id    <= w_sel;
            r_hold_addr  <= mem_req_addr_pyro;
            r_hold_we    <= mem_req_we_pyro;
            r_hold_wdata <= mem_req_wdata_pyro;
          end
        end
        HOLD: begin
          if (w_xfer) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PYRM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset_pyri) begin
    if (reset_pyri) begin
      r_rr_ptr <= REQ_FETCH;
    end else if (w_xfer) begin
      r_rr_ptr <= other_req(w_sel);
    end
  end
`endif

  pyrm_id_fifo #(
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (reset_pyri),
    .i_push    (w_xfer),
    .i_push_id (w_sel),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

endmodule

// File: tb/tb_pyrm_mem_arbiter.sv
// Directed bench for pyrm_mem_arbiter with a scoreboard of outstanding requester IDs.
module tb_pyrm_mem_arbiter;
  import pyrm_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_pyri;
  logic        if_req_valid_pyri;
  logic [63:0] if_req_addr_pyri;
  logic        if_req_retry_pyro;
  logic        dc_req_valid_pyri;
  logic [63:0] dc_req_addr_pyri;
  logic        dc_req_we_pyri;
  logic [63:0] dc_req_wdata_pyri;
  logic        dc_req_retry_pyro;
  logic        mem_req_valid_pyro;
  logic [63:0] mem_req_addr_pyro;
  logic        mem_req_we_pyro;
  logic [63:0] mem_req_wdata_pyro;
  logic        mem_req_retry_pyri;
  logic        mem_resp_valid_pyri;
  logic [63:0] mem_resp_data_pyri;
  logic        mem_resp_retry_pyro;
  logic        if_resp_valid_pyro;
  logic [63:0] if_resp_data_pyro;
  logic        if_resp_retry_pyri;
  logic        dc_resp_valid_pyro;
  logic [63:0] dc_resp_data_pyro;
  logic        dc_resp_retry_pyri;

  int      errors = 0;
  int      checks = 0;
  req_id_t sb_q[$];
  req_id_t exp_ptr;

  always #5 clk = ~clk;

  pyrm_mem_arbiter #(.MAX_OUT(4)) dut (
    .clk                 (clk),
    .reset_pyri          (reset_pyri),
    .if_req_valid_pyri   (if_req_valid_pyri),
    .if_req_addr_pyri    (if_req_addr_pyri),
    .if_req_retry_pyro   (if_req_retry_pyro),
    .dc_req_valid_pyri   (dc_req_valid_pyri),
    .dc_req_addr_pyri    (dc_req_addr_pyri),
    .dc_req_we_pyri      (dc_req_we_pyri),
    .dc_req_wdata_pyri   (dc_req_wdata_pyri),
    .dc_req_retry_pyro   (dc_req_retry_pyro),
    .mem_req_valid_pyro  (mem_req_valid_pyro),
    .mem_req_addr_pyro   (mem_req_addr_pyro),
    .mem_req_we_pyro     (mem_req_we_pyro),
    .mem_req_wdata_pyro  (mem_req_wdata_pyro),
    .mem_req_retry_pyri  (mem_req_retry_pyri),
    .mem_resp_valid_pyri (mem_resp_valid_pyri),
    .mem_resp_data_pyri  (mem_resp_data_pyri),
    .mem_resp_retry_pyro (mem_resp_retry_pyro),
    .if_resp_valid_pyro  (if_resp_valid_pyro),
    .if_resp_data_pyro   (if_resp_data_pyro),
    .if_resp_retry_pyri  (if_resp_retry_pyri),
    .dc_resp_valid_pyro  (dc_resp_valid_pyro),
    .dc_resp_data_pyro   (dc_resp_data_pyro),
    .dc_resp_retry_pyri  (dc_resp_retry_pyri)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid_pyri   = 1'b0;
    if_req_addr_pyri    = '0;
    dc_req_valid_pyri   = 1'b0;
    dc_req_addr_pyri    = '0;
    dc_req_we_pyri      = 1'b0;
    dc_req_wdata_pyri   = '0;
    mem_req_retry_pyri  = 1'b0;
    mem_resp_valid_pyri = 1'b0;
    mem_resp_data_pyri  = '0;
    if_resp_retry_pyri  = 1'b0;
    dc_resp_retry_pyri  = 1'b0;
  endtask

  // Caller drives the request inputs with mem retry low; this checks the
  // granted transfer, records the expected owner and advances one cycle.
  task automatic req_xfer(input string tag, input req_id_t id, input logic [63:0] addr,
                          input logic we, input logic [63:0] wdata);
    #2;
    chk({tag, "_valid"}, {63'd0, mem_req_valid_pyro}, 64'd1);
    chk({tag, "_addr"},  mem_req_addr_pyro, addr);
    chk({tag, "_we"},    {63'd0, mem_req_we_pyro}, {63'd0, we});
    chk({tag, "_wdata"}, mem_req_wdata_pyro, wdata);
    chk({tag, "_if_retry"}, {63'd0, if_req_retry_pyro}, {63'd0, id == REQ_DATA});
    chk({tag, "_dc_retry"}, {63'd0, dc_req_retry_pyro}, {63'd0, id == REQ_FETCH});
    sb_q.push_back(id);
    exp_ptr = other_req(id);
    $display("req  %s id=%0d addr=%h we=%0d wdata=%h", tag, id, addr, we, wdata);
    tick();
  endtask

  task automatic check_resp(input string tag, input logic [63:0] data);
    req_id_t id;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=response expected=no_outstanding", tag);
      return;
    end
    id = sb_q.pop_front();
    chk({tag, "_if_valid"}, {63'd0, if_resp_valid_pyro}, {63'd0, id == REQ_FETCH});
    chk({tag, "_dc_valid"}, {63'd0, dc_resp_valid_pyro}, {63'd0, id == REQ_DATA});
    chk({tag, "_data"}, (id == REQ_FETCH) ? if_resp_data_pyro : dc_resp_data_pyro, data);
    chk({tag, "_mretry"}, {63'd0, mem_resp_retry_pyro}, 64'd0);
    $display("resp %s id=%0d data=%h", tag, id, data);
  endtask

  task automatic do_resp(input string tag, input logic [63:0] data);
    mem_resp_valid_pyri = 1'b1;
    mem_resp_data_pyri  = data;
    #2;
    check_resp(tag, data);
    tick();
    mem_resp_valid_pyri = 1'b0;
  endtask

  initial begin
    idle_inputs();
    exp_ptr    = REQ_FETCH;
    reset_pyri = 1'b1;
    if_req_valid_pyri = 1'b1;
    #3;
    chk("rst_mvalid", {63'd0, mem_req_valid_pyro}, 64'd0);
    chk("rst_ifretry", {63'd0, if_req_retry_pyro}, 64'd1);
    chk("rst_dcretry", {63'd0, dc_req_retry_pyro}, 64'd1);
    chk("rst_mretry", {63'd0, mem_resp_retry_pyro}, 64'd0);
    chk("rst_ifrv", {63'd0, if_resp_valid_pyro}, 64'd0);
    chk("rst_dcrv", {63'd0, dc_resp_valid_pyro}, 64'd0);
    $display("txn  reset checked");
    tick();
    tick();
    idle_inputs();
    reset_pyri = 1'b0;
    tick();

    // Lone fetch: same-cycle grant, then response one cycle later.
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'h8000_0000;
    dc_req_we_pyri    = 1'b1;
    dc_req_wdata_pyri = 64'hFFFF;
    req_xfer("fetch0", REQ_FETCH, 64'h8000_0000, 1'b0, 64'd0);
    idle_inputs();
    do_resp("r_fetch0", 64'h1234);

    // Stray response with empty tracker is ignored.
    mem_resp_valid_pyri = 1'b1;
    mem_resp_data_pyri  = 64'hDEAD;
    #2;
    chk("empty_ifrv", {63'd0, if_resp_valid_pyro}, 64'd0);
    chk("empty_dcrv", {63'd0, dc_resp_valid_pyro}, 64'd0);
    chk("empty_mretry", {63'd0, mem_resp_retry_pyro}, 64'd0);
    $display("txn  stray response on empty tracker");
    tick();
    idle_inputs();

    // Contention with memory back-pressure: grant held stable for 3 cycles.
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'h100;
    dc_req_valid_pyri = 1'b1;
    dc_req_addr_pyri  = 64'h200;
    dc_req_we_pyri    = 1'b1;
    dc_req_wdata_pyri = 64'h55;
    mem_req_retry_pyri = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("hold%0d_valid", c), {63'd0, mem_req_valid_pyro}, 64'd1);
      chk($sformatf("hold%0d_addr", c), mem_req_addr_pyro, 64'h200);
      chk($sformatf("hold%0d_we", c), {63'd0, mem_req_we_pyro}, 64'd1);
      chk($sformatf("hold%0d_wdata", c), mem_req_wdata_pyro, 64'h55);
      chk($sformatf("hold%0d_ifretry", c), {63'd0, if_req_retry_pyro}, 64'd1);
      chk($sformatf("hold%0d_dcretry", c), {63'd0, dc_req_retry_pyro}, 64'd1);
      $display("txn  hold cycle %0d", c);
      tick();
      if_req_addr_pyri  = 64'h111 + 64'(c);
      dc_req_addr_pyri  = 64'h999;
      dc_req_wdata_pyri = 64'h77;
    end
    mem_req_retry_pyri = 1'b0;
    req_xfer("held_data", REQ_DATA, 64'h200, 1'b1, 64'h55);
    dc_req_valid_pyri = 1'b0;
    if_req_addr_pyri  = 64'h100;
    req_xfer("after_hold_fetch", REQ_FETCH, 64'h100, 1'b0, 64'd0);
    idle_inputs();
    do_resp("r_held_data", 64'hA1);
    do_resp("r_after_hold", 64'hA2);

    // Continuous contention: alternation or data-first, filling the tracker.
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'hF00;
    dc_req_valid_pyri = 1'b1;
    dc_req_addr_pyri  = 64'hD00;
    for (int k = 0; k < 4; k++) begin
      req_id_t want;
`ifdef PYRM_ARB_ROUND_ROBIN_EN
      want = exp_ptr;
`else
      want = REQ_DATA;
`endif
      req_xfer($sformatf("cont%0d", k), want, (want == REQ_DATA) ? 64'hD00 : 64'hF00,
               1'b0, 64'd0);
    end

    // Tracker full: fifth request must wait.
    dc_req_valid_pyri = 1'b0;
    #2;
    chk("full_mvalid", {63'd0, mem_req_valid_pyro}, 64'd0);
    chk("full_ifretry", {63'd0, if_req_retry_pyro}, 64'd1);
    chk("full_dcretry", {63'd0, dc_req_retry_pyro}, 64'd1);
    $display("txn  tracker full, fifth request held");
    tick();
    // Response in the same cycle as the fifth request: pop and push together.
    mem_resp_valid_pyri = 1'b1;
    mem_resp_data_pyri  = 64'hC0;
    #2;
    check_resp("r_cont0", 64'hC0);
    chk("full_pp_mvalid", {63'd0, mem_req_valid_pyro}, 64'd1);
    chk("full_pp_addr", mem_req_addr_pyro, 64'hF00);
    chk("full_pp_ifretry", {63'd0, if_req_retry_pyro}, 64'd0);
    sb_q.push_back(REQ_FETCH);
    exp_ptr = REQ_DATA;
    $display("req  fifth id=0 addr=%h (with simultaneous pop)", 64'hF00);
    tick();
    idle_inputs();
    for (int k = 1; k < 5; k++) begin
      do_resp($sformatf("r_drain%0d", k), 64'hC0 + 64'(k));
    end

    // In-order routing with a stalled data response.
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'h1000;
    req_xfer("ord_f1", REQ_FETCH, 64'h1000, 1'b0, 64'd0);
    idle_inputs();
    dc_req_valid_pyri = 1'b1;
    dc_req_addr_pyri  = 64'h2000;
    dc_req_we_pyri    = 1'b1;
    dc_req_wdata_pyri = 64'hAB;
    req_xfer("ord_d2", REQ_DATA, 64'h2000, 1'b1, 64'hAB);
    idle_inputs();
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'h3000;
    req_xfer("ord_f3", REQ_FETCH, 64'h3000, 1'b0, 64'd0);
    idle_inputs();
    do_resp("r_ord1", 64'hE1);
    mem_resp_valid_pyri = 1'b1;
    mem_resp_data_pyri  = 64'hE2;
    dc_resp_retry_pyri  = 1'b1;
    #2;
    chk("stall_dcrv", {63'd0, dc_resp_valid_pyro}, 64'd1);
    chk("stall_ifrv", {63'd0, if_resp_valid_pyro}, 64'd0);
    chk("stall_mretry", {63'd0, mem_resp_retry_pyro}, 64'd1);
    $display("txn  data response stalled one cycle");
    tick();
    dc_resp_retry_pyri = 1'b0;
    #2;
    check_resp("r_ord2", 64'hE2);
    tick();
    mem_resp_valid_pyri = 1'b0;
    do_resp("r_ord3", 64'hE3);

    // Reset with two outstanding and a held request.
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'h4000;
    req_xfer("pre_rst_f", REQ_FETCH, 64'h4000, 1'b0, 64'd0);
    idle_inputs();
    dc_req_valid_pyri = 1'b1;
    dc_req_addr_pyri  = 64'h5000;
    req_xfer("pre_rst_d", REQ_DATA, 64'h5000, 1'b0, 64'd0);
    idle_inputs();
    if_req_valid_pyri  = 1'b1;
    if_req_addr_pyri   = 64'h6000;
    mem_req_retry_pyri = 1'b1;
    tick();
    #2;
    chk("pre_rst_hold", {63'd0, mem_req_valid_pyro}, 64'd1);
    mem_resp_valid_pyri = 1'b1;
    mem_resp_data_pyri  = 64'hBAD;
    reset_pyri = 1'b1;
    #1;
    chk("arst_mvalid", {63'd0, mem_req_valid_pyro}, 64'd0);
    chk("arst_ifretry", {63'd0, if_req_retry_pyro}, 64'd1);
    chk("arst_dcretry", {63'd0, dc_req_retry_pyro}, 64'd1);
    chk("arst_mretry", {63'd0, mem_resp_retry_pyro}, 64'd0);
    chk("arst_ifrv", {63'd0, if_resp_valid_pyro}, 64'd0);
    chk("arst_dcrv", {63'd0, dc_resp_valid_pyro}, 64'd0);
    $display("txn  asynchronous reset mid-operation");
    sb_q.delete();
    exp_ptr = REQ_FETCH;
    tick();
    reset_pyri = 1'b0;
    if_req_valid_pyri  = 1'b0;
    mem_req_retry_pyri = 1'b0;
    #2;
    chk("post_rst_ifrv", {63'd0, if_resp_valid_pyro}, 64'd0);
    chk("post_rst_dcrv", {63'd0, dc_resp_valid_pyro}, 64'd0);
    chk("post_rst_mretry", {63'd0, mem_resp_retry_pyro}, 64'd0);
    chk("post_rst_mvalid", {63'd0, mem_req_valid_pyro}, 64'd0);
    $display("txn  stray response after reset dropped");
    tick();
    idle_inputs();
    if_req_valid_pyri = 1'b1;
    if_req_addr_pyri  = 64'h7000;
    req_xfer("post_rst_f", REQ_FETCH, 64'h7000, 1'b0, 64'd0);
    idle_inputs();
    do_resp("r_post_rst", 64'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
